// File: rtl/gf_mixcol_pipe.sv
// AES MixColumns / InvMixColumns over NCOL columns per beat, LAT-deep valid/ready pipeline.
// Optional GF_MIXCOL_BYPASS_EN: 2-bit in_mode, codes 2'b1x pass data through unchanged.
module gf_mixcol_pipe #(
  parameter int NCOL = 1,
  parameter int LAT  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
`ifdef GF_MIXCOL_BYPASS_EN
  input  logic [1:0]           in_mode,
`else
  input  logic                 in_mode,
`endif
  input  logic [32*NCOL-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [32*NCOL-1:0]   out_data,
  output logic [15:0]          beat_cnt
);

`ifdef GF_MIXCOL_BYPASS_EN
  localparam int MW = 2;
`else
  localparam int MW = 1;
`endif
  localparam int W = 32 * NCOL;

  // Per-byte xtime on all four bytes of a column.
  function automatic logic [31:0] xtime4(input logic [31:0] w);
    logic [31:0] o;
    o = '0;
    for (int i = 0; i < 4; i++)
      o[8*i +: 8] = {w[8*i +: 7], 1'b0} ^ (w[8*i+7] ? 8'h1b : 8'h00);
    return o;
  endfunction

  // Row index r (0 = top byte), taken modulo 4 so callers can rotate freely.
  function automatic logic [7:0] byte_at(input logic [31:0] w, input int r);
    return w[8*(3-(r%4)) +: 8];
  endfunction

  // Combines b, 2b, 4b, 8b into the circulant row products.
  function automatic logic [31:0] mix_comb(input logic [31:0] b,
                                           input logic [31:0] x2,
                                           input logic [31:0] x4,
                                           input logic [31:0] x8,
                                           input logic [MW-1:0] mode);
    logic [31:0] o;
    logic [7:0]  acc;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      if (mode[0])
        acc = (byte_at(x8, r)   ^ byte_at(x4, r)   ^ byte_at(x2, r))
            ^ (byte_at(x8, r+1) ^ byte_at(x2, r+1) ^ byte_at(b, r+1))
            ^ (byte_at(x8, r+2) ^ byte_at(x4, r+2) ^ byte_at(b, r+2))
            ^ (byte_at(x8, r+3) ^ byte_at(b, r+3));
      else
        acc = byte_at(x2, r)
            ^ (byte_at(x2, r+1) ^ byte_at(b, r+1))
            ^ byte_at(b, r+2)
            ^ byte_at(b, r+3);
      o[8*(3-r) +: 8] = acc;
    end
`ifdef GF_MIXCOL_BYPASS_EN
    if (mode[1])
      o = b;
`endif
    return o;
  endfunction

  logic [W-1:0] x2_c, x4_c, x8_c;

  for (genvar k = 0; k < NCOL; k++) begin : g_xt
    assign x2_c[32*k +: 32] = xtime4(in_data[32*k +: 32]);
    assign x4_c[32*k +: 32] = xtime4(x2_c[32*k +: 32]);
    assign x8_c[32*k +: 32] = xtime4(x4_c[32*k +: 32]);
  end

  if (LAT == 1) begin : g_lat1
    logic         v1;
    logic [W-1:0] d1;
    logic [W-1:0] res_c;

    for (genvar k = 0; k < NCOL; k++) begin : g_col
      assign res_c[32*k +: 32] = mix_comb(in_data[32*k +: 32], x2_c[32*k +: 32],
                                          x4_c[32*k +: 32], x8_c[32*k +: 32], in_mode);
    end

    assign in_ready = !v1 || out_ready;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v1 <= 1'b0;
        d1 <= '0;
      end else if (in_ready) begin
        v1 <= in_valid;
        if (in_valid)
          d1 <= res_c;
      end
    end

    assign out_valid = v1;
    assign out_data  = d1;
  end else begin : g_lat2
    logic          v1, v2;
    logic [MW-1:0] m1;
    logic [W-1:0]  b1, p2, p4, p8;
    logic [W-1:0]  d2;
    logic [W-1:0]  res_c;
    logic          adv2;

    for (genvar k = 0; k < NCOL; k++) begin : g_col
      assign res_c[32*k +: 32] = mix_comb(b1[32*k +: 32], p2[32*k +: 32],
                                          p4[32*k +: 32], p8[32*k +: 32], m1);
    end

    // A full stage 1 can only move when stage 2 drains or is empty.
    assign adv2     = !v2 || out_ready;
    assign in_ready = !v1 || adv2;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v1 <= 1'b0;
        v2 <= 1'b0;
        m1 <= '0;
        b1 <= '0;
        p2 <= '0;
        p4 <= '0;
        p8 <= '0;
        d2 <= '0;
      end else begin
        if (adv2) begin
          v2 <= v1;
          if (v1)
            d2 <= res_c;
        end
        if (in_ready) begin
          v1 <= in_valid;
          if (in_valid) begin
            m1 <= in_mode;
            b1 <= in_data;
            p2 <= x2_c;
            p4 <= x4_c;
            p8 <= x8_c;
          end
        end
      end
    end

    assign out_valid = v2;
    assign out_data  = d2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      beat_cnt <= '0;
    else if (out_valid && out_ready)
      beat_cnt <= beat_cnt + 16'd1;
  end

endmodule

// File: tb/tb_gf_mixcol_pipe.sv
// Scoreboard bench for gf_mixcol_pipe (NCOL=4, LAT=2): driver queues expected beats, monitor pops on delivery.
module tb_gf_mixcol_pipe;
  localparam int NCOL = 4;
  localparam int LAT  = 2;
  localparam int W    = 32 * NCOL;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
`ifdef GF_MIXCOL_BYPASS_EN
  logic [1:0]   in_mode = '0;
`else
  logic [0:0]   in_mode = '0;
`endif
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic [15:0]  beat_cnt;

  gf_mixcol_pipe #(.NCOL(NCOL), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  // Hand-computed column pairs; 0E*80=41, 09*80=EC, 0D*80=DA, 0B*80=F7.
  logic [31:0] fwd_in [7] = '{32'hDB135345, 32'hF20A225C, 32'h01010101, 32'hC6C6C6C6,
                              32'hD4D4D4D5, 32'h2D26314C, 32'h80000000};
  logic [31:0] fwd_out[7] = '{32'h8E4DA1BC, 32'h9FDC589D, 32'h01010101, 32'hC6C6C6C6,
                              32'hD5D5D7D6, 32'h4D7EBDF8, 32'h1B80809B};
  logic [31:0] inv_in [7] = '{32'h8E4DA1BC, 32'h9FDC589D, 32'h01010101, 32'hC6C6C6C6,
                              32'hD5D5D7D6, 32'h4D7EBDF8, 32'h80000000};
  logic [31:0] inv_out[7] = '{32'hDB135345, 32'hF20A225C, 32'h01010101, 32'hC6C6C6C6,
                              32'hD4D4D4D5, 32'h2D26314C, 32'h41ECDAF7};

  int           checks = 0;
  int           errors = 0;
  int           n_acc  = 0;
  logic [W-1:0] sb_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void mk_beat(input int n, input logic m,
                                  output logic [W-1:0] d, output logic [W-1:0] e);
    int idx;
    d = '0;
    e = '0;
    for (int k = 0; k < NCOL; k++) begin
      idx = (n + 3*k) % 7;
      d[32*k +: 32] = m ? inv_in[idx]  : fwd_in[idx];
      e[32*k +: 32] = m ? inv_out[idx] : fwd_out[idx];
    end
  endfunction

  task automatic send(input logic [W-1:0] d, input logic m, input logic [W-1:0] e,
                      output int waits);
    logic acc;
    waits    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = '0;
    in_mode[0] = m;
    while (1) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) begin
        sb_q.push_back(e);
        n_acc++;
      end
      @(posedge clk);
      #1;
      if (acc) break;
      waits++;
      if (waits > 200) begin
        errors++;
        $display("FAIL send_timeout: in_ready stuck low, got 0 expected 1");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // Monitor: delivered beats against the scoreboard, stall hold, delivered count.
  int           model_cnt = 0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data;
  logic [W-1:0] exp_d;

  always @(negedge clk) begin
    if (rst) begin
      model_cnt  = 0;
      prev_stall = 1'b0;
    end else begin
      checks++;
      if (beat_cnt !== model_cnt[15:0]) begin
        errors++;
        $display("FAIL beat_cnt: got %0d expected %0d", beat_cnt, model_cnt[15:0]);
      end
      if (prev_stall) begin
        checks++;
        if (!out_valid || out_data !== prev_data) begin
          errors++;
          $display("FAIL stall_hold: got valid=%b data=%h expected valid=1 data=%h",
                   out_valid, out_data, prev_data);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %h expected no beat", out_data);
        end else begin
          exp_d = sb_q.pop_front();
          if (out_data !== exp_d) begin
            errors++;
            $display("FAIL out_data: got %h expected %h", out_data, exp_d);
          end
        end
        model_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] d, e;
    int           w, tot_w, lat, base;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_beat_cnt",  128'(beat_cnt),  128'(0));
    chk("rst_out_data",  out_data,        128'(0));
    rst = 1'b0;
    #1;
    chk("rst_in_ready",  128'(in_ready),  128'(1));
    @(posedge clk);
    #1;

    // Single forward column, latency measured from the accepting edge.
    send({32'h0, 32'h0, 32'h0, 32'hDB135345}, 1'b0, {32'h0, 32'h0, 32'h0, 32'h8E4DA1BC}, w);
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 128'(lat), 128'(LAT));
    repeat (3) @(posedge clk);
    #1;

    // Inverse columns including the 0x80 single-byte case.
    send({32'h80000000, 32'h9FDC589D, 32'h8E4DA1BC, 32'h01010101}, 1'b1,
         {32'h41ECDAF7, 32'hF20A225C, 32'hDB135345, 32'h01010101}, w);
    repeat (4) @(posedge clk);
    #1;

    // 16 back-to-back beats, alternating mode.
    tot_w = 0;
    for (int n = 0; n < 16; n++) begin
      mk_beat(n, n[0], d, e);
      send(d, n[0], e, w);
      tot_w += w;
    end
    repeat (LAT + 2) @(posedge clk);
    #1;
    chk("stream_bubbles", 128'(tot_w), 128'(0));
    chk("beat_cnt_stream", 128'(beat_cnt), 128'(n_acc));

    // Output stalled for 5 cycles while a stream is offered.
    out_ready = 1'b0;
    base = n_acc;
    fork
      begin
        for (int n = 0; n < 8; n++) begin
          mk_beat(n + 5, ~n[0], d, e);
          send(d, ~n[0], e, w);
        end
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("stall_absorbed", 128'(n_acc - base), 128'(LAT));
        chk("stall_in_ready", 128'(in_ready), 128'(0));
        out_ready = 1'b1;
      end
    join
    repeat (LAT + 3) @(posedge clk);
    #1;
    chk("beat_cnt_stall", 128'(beat_cnt), 128'(n_acc));

    // Reset with two beats in flight.
    out_ready = 1'b0;
    mk_beat(2, 1'b0, d, e);
    send(d, 1'b0, e, w);
    mk_beat(3, 1'b1, d, e);
    send(d, 1'b1, e, w);
    rst = 1'b1;
    #1;
    chk("flush_out_valid", 128'(out_valid), 128'(0));
    chk("flush_beat_cnt",  128'(beat_cnt),  128'(0));
    chk("flush_out_data",  out_data,        128'(0));
    sb_q.delete();
    n_acc = 0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("post_rst_in_ready", 128'(in_ready), 128'(1));
    mk_beat(4, 1'b1, d, e);
    send(d, 1'b1, e, w);
    repeat (LAT + 3) @(posedge clk);
    #1;
    chk("beat_cnt_post_rst", 128'(beat_cnt), 128'(n_acc));
    chk("sb_empty", 128'(sb_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
